fetch: RTL and testbench

Instruction fetch stage, directly upstream of decode in the RV32 core. Owns the PC and issues in-order word requests to instruction memory. Buffers returned instruction words with their PCs in a small FIFO. Presents one {pc, instr} pair per cycle to decode over a valid/ready handshake, and supports redirect (branch/jump/flush) from later stages.

---
 rtl/core_types_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/fetch.sv | 108 ++++++++++
 tb/tb_fetch.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/core_types_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// core_types_pkg : types and constants shared by fetch and decode
// Revision 1.0
// ----------------------------------------------------------------------------
package core_types_pkg;

  // One fetched instruction together with the address it came from
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  // Instruction fetches are always word aligned; the low two bits are dropped
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_fifo : registered FIFO of fetch_entry_t with flush and occupancy count
// Revision 1.0
// ----------------------------------------------------------------------------
module fetch_fifo
  import core_types_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_pop;

  // Popping an empty FIFO is a no-op so the caller need not qualify pop
  assign do_pop = pop && !empty;
  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign head   = mem[rd_ptr];

  // Storage and pointers; DEPTH is a power of two so pointers wrap for free
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  // A push into a full FIFO is only legal when the head leaves in the same cycle
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && !flush && full && !pop));

endmodule
`default_nettype wire

// File: rtl/fetch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch : RV32 instruction fetch stage (PC, credit-limited imem requests,
//         instruction buffer, redirect with stale-response dropping)
// Revision 1.0
// ----------------------------------------------------------------------------
module fetch
  import core_types_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        decode_valid,
  input  logic        decode_ready,
  output logic [31:0] decode_instr,
  output logic [31:0] decode_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   used;
  logic          req_fire;
  logic          rsp_keep;
  logic          dec_fire;
  logic          fifo_full;
  logic          fifo_empty;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  // Credits: outstanding requests plus buffered words never exceed DEPTH,
  // so every response is guaranteed a slot and needs no back-pressure.
  assign used           = {1'b0, inflight} + {1'b0, fifo_count};
  assign imem_req_valid = rst && (used < (CW+1)'(DEPTH)) && !redirect_valid;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses return in order, so once stale ones are drained the oldest
  // outstanding request was issued inflight words behind the current pc.
  assign rsp_keep         = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
  assign push_entry.pc    = pc - (32'(inflight) << 2);
  assign push_entry.instr = imem_rsp_data;

  assign decode_valid = !fifo_empty;
  assign decode_instr = head.instr;
  assign decode_pc    = head.pc;
  assign dec_fire     = decode_valid && decode_ready;

  // PC, in-flight and drop counters; a redirect marks every request still
  // outstanding after this cycle's response as stale
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        pc       <= word_align(redirect_pc);
        drop_cnt <= inflight - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) begin
          pc <= pc + 32'd4;
        end
        if (imem_rsp_valid && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - 1'b1;
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_keep),
    .push_data (push_entry),
    .pop       (dec_fire),
    .flush     (redirect_valid),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Memory must only answer requests that were actually accepted
  a_rsp_has_req: assert property (@(posedge clk) disable iff (!rst)
    !(imem_rsp_valid && (inflight == '0)));

  // Credit accounting alone must keep the buffer from overflowing
  a_credit_ok: assert property (@(posedge clk) disable iff (!rst)
    !(rsp_keep && fifo_full && !dec_fire));

endmodule
`default_nettype wire

// File: tb/tb_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fetch : randomized scoreboard bench for the fetch stage
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_fetch;
  import core_types_pkg::*;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          ITERS  = 4000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = '0;
  logic        decode_valid;
  logic        decode_ready   = 1'b0;
  logic [31:0] decode_instr;
  logic [31:0] decode_pc;

  always #5 clk = ~clk;

  fetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .decode_valid   (decode_valid),
    .decode_ready   (decode_ready),
    .decode_instr   (decode_instr),
    .decode_pc      (decode_pc)
  );

  int checks = 0;
  int errors = 0;
  int n_dec  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Contents of instruction memory; address 0 holds a LUI
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    logic [31:0] h;
    h = (a * 32'h9E37_79B1) ^ 32'h0000_0037;
    return (a == 32'h0) ? 32'h0F0F_0037 : h;
  endfunction

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] addr; int unsigned ep; } out_t;
  fetch_entry_t exp_q[$];   // words decode should see, in order
  out_t         out_q[$];   // requests accepted by memory, not yet answered
  logic [31:0]  model_pc = RST_PC;
  int unsigned  epoch = 0;

  logic        cyc_valid = 1'b0;
  logic        cyc_req_fire, cyc_rsp_valid, cyc_redirect;
  logic [31:0] cyc_redirect_pc;

  // Monitor: compare what the DUT presents this cycle, then record the cycle
  always @(negedge clk) begin
    fetch_entry_t e;
    if (!rst) begin
      cyc_valid = 1'b0;
    end else begin
      chk("req_valid", 32'(imem_req_valid),
          32'((out_q.size() + exp_q.size() < DEPTH) && !redirect_valid));
      if (imem_req_valid) chk("req_addr", imem_req_addr, model_pc);
      chk("decode_valid", 32'(decode_valid), 32'(exp_q.size() != 0));
      if (decode_valid && decode_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("decode_pc", decode_pc, e.pc);
        chk("decode_instr", decode_instr, e.instr);
        n_dec++;
      end
      cyc_req_fire    = imem_req_valid && imem_req_ready;
      cyc_rsp_valid   = imem_rsp_valid;
      cyc_redirect    = redirect_valid;
      cyc_redirect_pc = redirect_pc;
      cyc_valid       = 1'b1;
    end
  end

  // Model update at the clock edge: stale responses belong to an older epoch
  always @(posedge clk or negedge rst) begin
    out_t o;
    if (!rst) begin
      exp_q.delete();
      out_q.delete();
      model_pc = RST_PC;
      epoch++;
    end else if (cyc_valid) begin
      if (cyc_rsp_valid && out_q.size() != 0) begin
        o = out_q.pop_front();
        if (o.ep == epoch && !cyc_redirect)
          exp_q.push_back('{pc: o.addr, instr: instr_of(o.addr)});
      end
      if (cyc_req_fire) begin
        out_q.push_back('{addr: model_pc, ep: epoch});
        model_pc = model_pc + 32'd4;
      end
      if (cyc_redirect) begin
        exp_q.delete();
        epoch++;
        model_pc = {cyc_redirect_pc[31:2], 2'b00};
      end
      cyc_valid = 1'b0;
    end
  end

  // ---------------- stimulus: imem model and downstream ----------------
  typedef struct { logic [31:0] addr; int rdy; } pend_t;
  pend_t pend[$];
  int    cycle = 0;

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'h0);
    chk({tag, "_req_addr"}, imem_req_addr, RST_PC);
    chk({tag, "_decode_valid"}, 32'(decode_valid), 32'h0);
    chk({tag, "_decode_instr"}, decode_instr, 32'h0);
    chk({tag, "_decode_pc"}, decode_pc, 32'h0);
  endtask

  initial begin
    int hold_dec;
    hold_dec = 0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    rst = 1'b1;

    for (int i = 0; i < ITERS; i++) begin
      @(negedge clk);
      if (rst && imem_req_valid && imem_req_ready)
        pend.push_back('{addr: imem_req_addr, rdy: cycle + 1 + int'($urandom_range(0, 2))});
      @(posedge clk);
      cycle++;

      if (i == ITERS / 2) begin
        // Asynchronous reset in the middle of a stalled stream
        #3 rst = 1'b0;
        #1 check_reset_outputs("midreset");
        pend.delete();
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        decode_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        continue;
      end

      #1;
      if (i >= ITERS / 2 - 15 && i < ITERS / 2) hold_dec = 1;
      else if ((i % 250) < 25) hold_dec = 1;
      else hold_dec = 0;

      imem_req_ready = (i % 97 < 6) ? 1'b0 : (($urandom % 5) != 0);
      if (pend.size() != 0 && pend[0].rdy <= cycle && ($urandom % 4) != 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr_of(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
      end
      decode_ready = hold_dec ? 1'b0 : (($urandom % 4) != 0);
      if (i >= ITERS / 2 - 15 && i < ITERS / 2) redirect_valid = 1'b0;
      else redirect_valid = (($urandom % 18) == 0);
      redirect_pc = (($urandom % 8) == 0) ? (32'hFFFF_FFF4 | 32'($urandom % 4))
                                          : 32'($urandom_range(0, 4095));
    end

    @(negedge clk);
    chk("decodes_seen_enough", 32'(n_dec > 200), 32'h1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
